prbs_checker: RTL

Serial receive-side checker for the 8-bit PRBS produced by the team's LFSR generator: feedback polynomial x^8+x^6+x^5+x^4+1, MSB-first serial output. The block self-synchronises to the incoming bit stream, declares lock, and counts bit errors. It also measures the sequence period, which must be 255 for any non-zero seed. It sits at the far end of a serial link or loopback path, driven by the generator's `out` bit.

---
 rtl/prbs_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side checker for the 8-bit PRBS with feedback x^8+x^6+x^5+x^4+1,
// sent MSB first. Self-synchronises to the incoming stream, declares lock,
// counts bit errors and measures the sequence period.
//
// Parameters:
//   LOCK_CNT  consecutive correct predictions needed to lock (1..255)
//   WIN       loss-of-lock observation window in valid bits (2..256)
//   LOSS_THR  errors within one window that force loss of lock (1..WIN)
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   din        received serial PRBS bit
//   din_vld    din is sampled only when this is 1
//   clr        synchronous clear of err_cnt, bit_cnt, period_vld
//   locked     checker is in LOCKED
//   err        one-cycle pulse: previous valid bit mismatched while LOCKED
//   err_cnt    saturating error count
//   bit_cnt    saturating count of valid bits checked while LOCKED
//   period     measured sequence period in bits
//   period_vld period holds a completed measurement
module prbs_checker #(
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_vld,
  input  logic        clr,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt,
  output logic [8:0]  period,
  output logic        period_vld
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [8:0] WIN_LAST  = 9'(WIN - 1);
  localparam logic [8:0] LOSS_LIM  = 9'(LOSS_THR);
  localparam logic [8:0] PER_MAX   = 9'h1FF;

  state_t     state;
  logic [7:0] h;          // h[0] is the newest bit
  logic [3:0] fill;
  logic [7:0] match_cnt;
  logic [7:0] ref_state;
  logic [8:0] per_cnt;
  logic [8:0] win_bits;
  logic [8:0] win_errs;

  logic       p;
  logic       miss;
  logic [7:0] h_rx;
  logic [7:0] h_pred;
  logic [8:0] win_errs_next;
  logic       loss;

  always_comb begin
    p             = h[7] ^ h[5] ^ h[4] ^ h[3];
    miss          = din ^ p;
    h_rx          = {h[6:0], din};
    h_pred        = {h[6:0], p};
    win_errs_next = win_errs + {8'd0, miss};
    loss          = miss && (win_errs_next == LOSS_LIM);
  end

  // NOTE: every register, including the outputs, sits on the asynchronous
  // reset so the outputs drop as soon as rst goes low, without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      h          <= '0;
      fill       <= '0;
      match_cnt  <= '0;
      ref_state  <= '0;
      per_cnt    <= '0;
      win_bits   <= '0;
      win_errs   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      bit_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      err <= 1'b0;
      if (din_vld) begin
        case (state)
          SEARCH: begin
            h    <= h_rx;
            fill <= fill + 4'd1;
            if (fill == 4'd7) begin
              state     <= VERIFY;
              match_cnt <= '0;
            end
          end

          VERIFY: begin
            // Received bits always enter the register, so a corrupted
            // history is flushed out and the checker resynchronises.
            h <= h_rx;
            if (!miss && (h != 8'd0)) begin
              if (match_cnt == LOCK_LAST) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                match_cnt  <= '0;
                ref_state  <= h_rx;
                per_cnt    <= '0;
                win_bits   <= '0;
                win_errs   <= '0;
                period_vld <= 1'b0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            // Free-run on the prediction so line errors never corrupt h.
            h   <= h_pred;
            err <= miss;
            if (miss && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
            if (bit_cnt != 32'hFFFF_FFFF) bit_cnt <= bit_cnt + 32'd1;

            if (h_pred == ref_state) begin
              period     <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 9'd1;
              period_vld <= 1'b1;
              per_cnt    <= '0;
            end else if (per_cnt != PER_MAX) begin
              per_cnt <= per_cnt + 9'd1;
            end

            if (loss) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              fill     <= '0;
              h        <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else if (win_bits == WIN_LAST) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 9'd1;
              win_errs <= win_errs_next;
            end
          end

          default: state <= SEARCH;
        endcase
      end

      // NOTE: placed last so that, of the non-blocking assignments to the
      // same counter in this block, the clear is the one that takes effect;
      // an error coinciding with clr is therefore not counted.
      if (clr) begin
        err_cnt    <= '0;
        bit_cnt    <= '0;
        period_vld <= 1'b0;
      end
    end
  end

endmodule
